// File: rtl/rf_scoreboard.sv
// Register file with two combinational read ports, one write port and a
// per-register outstanding-write counter used by hazard control to stall or forward.
module rf_scoreboard #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 2,
    parameter int CNT_BITS  = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_BITS-1:0]      rd_addr1,
    output logic [WORD_SIZE-1:0]      rd_data1,
    output logic                      rd_busy1,
    input  logic [ADDR_BITS-1:0]      rd_addr2,
    output logic [WORD_SIZE-1:0]      rd_data2,
    output logic                      rd_busy2,
    input  logic                      issue_valid,
    input  logic [ADDR_BITS-1:0]      issue_addr,
    output logic                      issue_ready,
    input  logic                      wr_en,
    input  logic [ADDR_BITS-1:0]      wr_addr,
    input  logic [WORD_SIZE-1:0]      wr_data,
    input  logic                      flush,
    output logic [(1<<ADDR_BITS)-1:0] busy_vec,
    output logic                      err_underflow
);

    localparam int                  NUM_REG = 1 << ADDR_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [WORD_SIZE-1:0] r_regs [NUM_REG];
    logic [CNT_BITS-1:0]  r_cnt  [NUM_REG];
    logic                 r_err;

    logic [NUM_REG-1:0]   w_inc;
    logic [NUM_REG-1:0]   w_dec;
    logic                 w_issue_ok;
    logic [ADDR_BITS-1:0] w_raddr [2];
    logic [WORD_SIZE-1:0] w_rdata [2];
    logic                 w_rbusy [2];

    // Register 0 is treated as a constant when ZERO_REG is set: no storage, no scoreboard.
    function automatic logic is_zero(input logic [ADDR_BITS-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign w_issue_ok = is_zero(issue_addr) || (r_cnt[issue_addr] != CNT_MAX);

    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            w_inc[i] = issue_valid && w_issue_ok && (issue_addr == ADDR_BITS'(i))
                       && !is_zero(ADDR_BITS'(i));
            w_dec[i] = wr_en && (wr_addr == ADDR_BITS'(i)) && !is_zero(ADDR_BITS'(i));
        end
    end

    assign w_raddr[0] = rd_addr1;
    assign w_raddr[1] = rd_addr2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            w_rdata[p] = r_regs[w_raddr[p]];
            if ((BYPASS != 0) && wr_en && (wr_addr == w_raddr[p])) begin
                w_rdata[p] = wr_data;
            end
            if (is_zero(w_raddr[p])) begin
                w_rdata[p] = '0;
            end
            // A final retire landing this cycle clears busy early; a retire at count 0 never reports busy.
            w_rbusy[p] = r_cnt[w_raddr[p]] > CNT_BITS'(w_dec[w_raddr[p]]);
        end
    end

    assign rd_data1      = w_rdata[0];
    assign rd_data2      = w_rdata[1];
    assign rd_busy1      = w_rbusy[0];
    assign rd_busy2      = w_rbusy[1];
    assign issue_ready   = w_issue_ok;
    assign err_underflow = r_err;

    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            busy_vec[i] = (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data array is reset too, because reads straight after reset must return 0.
            for (int i = 0; i < NUM_REG; i++) begin
                r_regs[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_err <= 1'b0;
        end else begin
            // NOTE: non-blocking so every counter sees the pre-edge state of all others.
            if (wr_en && !is_zero(wr_addr)) begin
                r_regs[wr_addr] <= wr_data;
            end
            for (int i = 0; i < NUM_REG; i++) begin
                if (w_dec[i] && !w_inc[i] && (r_cnt[i] == '0)) begin
                    r_err <= 1'b1;
                end
                if (flush) begin
                    r_cnt[i] <= '0;
                end else if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_BITS'(1);
                end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CNT_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench: dut0 uses defaults (BYPASS=1, ZERO_REG=0), dut1 uses BYPASS=0, ZERO_REG=1.
// Both share stimulus and are compared against a behavioural model.
module tb_rf_scoreboard;

    logic        clk;
    logic        reset;
    logic [1:0]  rd_addr1, rd_addr2, issue_addr, wr_addr;
    logic        issue_valid, wr_en, flush;
    logic [15:0] wr_data;

    logic [15:0] rd_data1 [2];
    logic [15:0] rd_data2 [2];
    logic        rd_busy1 [2];
    logic        rd_busy2 [2];
    logic        issue_ready [2];
    logic [3:0]  busy_vec [2];
    logic        err_underflow [2];

    int n_checks = 0;
    int n_fail   = 0;

    rf_scoreboard u_dut0 (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1[0]), .rd_busy1(rd_busy1[0]),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2[0]), .rd_busy2(rd_busy2[0]),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush),
        .busy_vec(busy_vec[0]), .err_underflow(err_underflow[0])
    );

    rf_scoreboard #(.BYPASS(0), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1[1]), .rd_busy1(rd_busy1[1]),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2[1]), .rd_busy2(rd_busy2[1]),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush),
        .busy_vec(busy_vec[1]), .err_underflow(err_underflow[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain values and integer counts per register.
    logic [15:0] m_reg [2][4];
    int          m_cnt [2][4];
    bit          m_err [2];

    function automatic bit is_z(int k, int a);
        return (k == 1) && (a == 0);
    endfunction

    function automatic bit exp_ready(int k);
        return is_z(k, issue_addr) || (m_cnt[k][issue_addr] < 3);
    endfunction

    function automatic logic [15:0] exp_data(int k, int a);
        if (is_z(k, a)) return 16'h0;
        if (k == 0 && wr_en && wr_addr == a) return wr_data;
        return m_reg[k][a];
    endfunction

    function automatic bit exp_busy(int k, int a);
        int retiring = (wr_en && wr_addr == a && !is_z(k, a)) ? 1 : 0;
        return m_cnt[k][a] - retiring > 0;
    endfunction

    function automatic logic [3:0] exp_bvec(int k);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (m_cnt[k][i] != 0);
        return v;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 4; i++) begin
                    m_reg[k][i] = 16'h0;
                    m_cnt[k][i] = 0;
                end
                m_err[k] = 1'b0;
            end else begin
                bit accept;
                accept = issue_valid && exp_ready(k);
                if (wr_en && !is_z(k, wr_addr)) m_reg[k][wr_addr] = wr_data;
                for (int i = 0; i < 4; i++) begin
                    int inc, dec, next;
                    inc  = (accept && issue_addr == i && !is_z(k, i)) ? 1 : 0;
                    dec  = (wr_en && wr_addr == i && !is_z(k, i)) ? 1 : 0;
                    next = m_cnt[k][i] + inc - dec;
                    if (next < 0) begin
                        m_err[k] = 1'b1;
                        next = 0;
                    end
                    m_cnt[k][i] = flush ? 0 : next;
                end
            end
        end
    end

    task automatic idle();
        issue_valid = 0; issue_addr = 0; wr_en = 0; wr_addr = 0;
        wr_data = 0; flush = 0; rd_addr1 = 0; rd_addr2 = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (busy_vec[k] !== 4'h0 || issue_ready[k] !== 1'b1 || err_underflow[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: busy_vec=%h ready=%b err=%b, want 0/1/0",
                         k, busy_vec[k], issue_ready[k], err_underflow[k]);
            end
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr1 = 2'(a); #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (rd_data1[k] !== 16'h0) begin
                    n_fail++;
                    $display("FAIL reset_reg dut%0d r%0d: got %h want 0000", k, a, rd_data1[k]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1; wr_addr = 1; wr_data = 16'h1234;
        issue_valid = 1; issue_addr = 1;
        @(negedge clk);
        idle();
        rd_addr1 = 1; #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rd_data1[k] !== 16'h1234) begin
                n_fail++;
                $display("FAIL write_read dut%0d: got %h want 1234", k, rd_data1[k]);
            end
        end
        for (int a = 0; a < 4; a++) begin
            if (a == 1) continue;
            rd_addr2 = 2'(a); #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (rd_data2[k] !== 16'h0) begin
                    n_fail++;
                    $display("FAIL other_reg dut%0d r%0d: got %h want 0000", k, a, rd_data2[k]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 1; wr_addr = 2; wr_data = 16'hBEEF;
        issue_valid = 1; issue_addr = 2; rd_addr2 = 2;
        #1;
        n_checks++;
        if (rd_data2[0] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL bypass_on: got %h want beef", rd_data2[0]);
        end
        n_checks++;
        if (rd_data2[1] !== 16'h0000) begin
            n_fail++;
            $display("FAIL bypass_off: got %h want 0000", rd_data2[1]);
        end
        @(negedge clk);
        idle(); rd_addr2 = 2; #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rd_data2[k] !== 16'hBEEF) begin
                n_fail++;
                $display("FAIL bypass_commit dut%0d: got %h want beef", k, rd_data2[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_issue_saturate();
        idle();
        for (int j = 0; j < 3; j++) begin
            issue_valid = 1; issue_addr = 3; #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (issue_ready[k] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL issue_ready_%0d dut%0d: got %b want 1", j, k, issue_ready[k]);
                end
            end
            @(negedge clk);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (busy_vec[k][3] !== 1'b1 || issue_ready[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL saturated dut%0d: busy3=%b ready=%b want 1/0",
                         k, busy_vec[k][3], issue_ready[k]);
            end
        end
        @(negedge clk);
        idle();
        for (int j = 0; j < 3; j++) begin
            wr_en = 1; wr_addr = 3; wr_data = 16'($urandom); rd_addr1 = 3; #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (rd_busy1[k] !== (j < 2)) begin
                    n_fail++;
                    $display("FAIL retire_busy_%0d dut%0d: got %b want %b", j, k, rd_busy1[k], j < 2);
                end
            end
            @(negedge clk);
        end
        idle(); issue_addr = 3; #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (busy_vec[k][3] !== 1'b0 || issue_ready[k] !== 1'b1 || err_underflow[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL drained dut%0d: busy3=%b ready=%b err=%b want 0/1/0",
                         k, busy_vec[k][3], issue_ready[k], err_underflow[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_issue_retire_flush();
        idle();
        issue_valid = 1; issue_addr = 1;
        @(negedge clk);
        wr_en = 1; wr_addr = 1; wr_data = 16'h1111; rd_addr1 = 1; #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rd_busy1[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL inc_dec_busy dut%0d: got %b want 0", k, rd_busy1[k]);
            end
        end
        @(negedge clk);
        idle(); #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (busy_vec[k] !== 4'b0010) begin
                n_fail++;
                $display("FAIL inc_dec_hold dut%0d: got %b want 0010", k, busy_vec[k]);
            end
        end
        flush = 1; issue_valid = 1; issue_addr = 2;
        wr_en = 1; wr_addr = 1; wr_data = 16'h5A5A;
        @(negedge clk);
        idle(); rd_addr1 = 1; #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (busy_vec[k] !== 4'b0000 || rd_data1[k] !== 16'h5A5A) begin
                n_fail++;
                $display("FAIL flush dut%0d: busy_vec=%b r1=%h want 0000/5a5a",
                         k, busy_vec[k], rd_data1[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_underflow();
        idle(); #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (err_underflow[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL err_clean dut%0d: got %b want 0", k, err_underflow[k]);
            end
        end
        wr_en = 1; wr_addr = 0; wr_data = 16'h0077;
        @(negedge clk);
        idle(); #1;
        n_checks++;
        if (err_underflow[0] !== 1'b1 || rd_data1[0] !== 16'h0077) begin
            n_fail++;
            $display("FAIL underflow dut0: err=%b r0=%h want 1/0077", err_underflow[0], rd_data1[0]);
        end
        n_checks++;
        if (err_underflow[1] !== 1'b0 || rd_data1[1] !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_reg dut1: err=%b r0=%h want 0/0000", err_underflow[1], rd_data1[1]);
        end
        issue_valid = 1; issue_addr = 2;
        repeat (3) @(negedge clk);
        idle(); #1;
        n_checks++;
        if (err_underflow[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky dut0: got %b want 1", err_underflow[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        idle();
        issue_valid = 1; issue_addr = 1;
        @(negedge clk);
        issue_addr = 2;
        @(negedge clk);
        reset = 1; issue_addr = 3; wr_en = 1; wr_addr = 2; wr_data = 16'hDEAD;
        @(negedge clk);
        reset = 0; idle(); #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (busy_vec[k] !== 4'h0 || issue_ready[k] !== 1'b1 || err_underflow[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL midop_reset dut%0d: busy_vec=%h ready=%b err=%b want 0/1/0",
                         k, busy_vec[k], issue_ready[k], err_underflow[k]);
            end
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr2 = 2'(a); #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (rd_data2[k] !== 16'h0) begin
                    n_fail++;
                    $display("FAIL midop_reg dut%0d r%0d: got %h want 0000", k, a, rd_data2[k]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset       = ($urandom_range(63) == 0);
            flush       = ($urandom_range(15) == 0);
            issue_valid = $urandom_range(1);
            issue_addr  = 2'($urandom);
            wr_en       = $urandom_range(1);
            wr_addr     = 2'($urandom);
            wr_data     = 16'($urandom);
            rd_addr1    = 2'($urandom);
            rd_addr2    = ($urandom_range(3) == 0) ? wr_addr : 2'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (rd_data1[k] !== exp_data(k, rd_addr1) || rd_data2[k] !== exp_data(k, rd_addr2)) begin
                    n_fail++;
                    $display("FAIL rand_data dut%0d cyc%0d: got %h/%h want %h/%h", k, c,
                             rd_data1[k], rd_data2[k], exp_data(k, rd_addr1), exp_data(k, rd_addr2));
                end
                n_checks++;
                if (rd_busy1[k] !== exp_busy(k, rd_addr1) || rd_busy2[k] !== exp_busy(k, rd_addr2)) begin
                    n_fail++;
                    $display("FAIL rand_busy dut%0d cyc%0d: got %b/%b want %b/%b", k, c,
                             rd_busy1[k], rd_busy2[k], exp_busy(k, rd_addr1), exp_busy(k, rd_addr2));
                end
                n_checks++;
                if (issue_ready[k] !== exp_ready(k) || busy_vec[k] !== exp_bvec(k)
                    || err_underflow[k] !== m_err[k]) begin
                    n_fail++;
                    $display("FAIL rand_state dut%0d cyc%0d: ready=%b bvec=%b err=%b want %b/%b/%b",
                             k, c, issue_ready[k], busy_vec[k], err_underflow[k],
                             exp_ready(k), exp_bvec(k), m_err[k]);
                end
            end
            @(negedge clk);
        end
        reset = 0; idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_issue_saturate();
        test_issue_retire_flush();
        test_underflow();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
